// File: rtl/phase_cal_fsm.sv
// Phase-select calibration FSM: sweeps NPHASE codes, averages phase-detector samples per code,
// then locks onto the strongest circular 0->1 edge of the stored profile (with offset), or flags an error.
module phase_cal_fsm #(
    parameter int NPHASE  = 16,
    parameter int CODE_W  = $clog2(NPHASE),
    parameter int SAMP_W  = 4,
    parameter int AVG_MAX = 7
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start_phase_lock,
    input  logic              phase_detect,
    input  logic              enable,
    input  logic [2:0]        avg_log2,
    input  logic [7:0]        settle_cyc,
    input  logic [SAMP_W-1:0] min_edge,
    input  logic [CODE_W-1:0] code_offset,
    input  logic              phase_adjust_ovrd_sel,
    input  logic              phase_locked_ovrd,
    input  logic [CODE_W-1:0] phase_sel_code_ovrd,
    output logic [CODE_W-1:0] phase_sel_code,
    output logic              phase_locked,
    output logic              phase_err,
    output logic              busy,
    output logic [SAMP_W-1:0] edge_strength
);

    localparam int CNT_W = AVG_MAX + 1;
    localparam int NW    = CNT_W + SAMP_W;
    localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(NPHASE - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, EVAL, DONE} state_t;

    // Normalise a ones count to SAMP_W bits of fraction, clamping full scale to all-ones.
    function automatic logic [SAMP_W-1:0] norm_sat(input logic [CNT_W-1:0] ones,
                                                    input logic [2:0] sh);
        logic [NW-1:0] w;
        w = {ones, {SAMP_W{1'b0}}} >> sh;
        if (w > NW'((1 << SAMP_W) - 1)) return '1;
        return w[SAMP_W-1:0];
    endfunction

    // Rising-step magnitude only; falling steps count as no edge.
    function automatic logic [SAMP_W-1:0] edge_diff(input logic [SAMP_W-1:0] cur,
                                                     input logic [SAMP_W-1:0] prv);
        return (cur >= prv) ? (cur - prv) : '0;
    endfunction

    logic [1:0]        sync_q;
    logic              start_s;
    state_t            state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d, ones_q, ones_d, smp_last, ones_inc;
    logic [CODE_W-1:0] code_q, code_d, eval_idx_q, eval_idx_d, best_q, best_d, cur_best;
    logic [SAMP_W-1:0] max_q, max_d, cur_max, diff, edge_q, edge_d;
    logic              locked_q, locked_d, err_q, err_d;
    logic [SAMP_W-1:0] samp_q [NPHASE];
    logic [SAMP_W-1:0] samp_d [NPHASE];

    assign start_s  = sync_q[1];
    assign smp_last = (CNT_W'(1) << avg_log2) - CNT_W'(1);
    assign ones_inc = ones_q + CNT_W'(phase_detect);
    assign diff     = edge_diff(samp_q[eval_idx_q], samp_q[eval_idx_q - CODE_W'(1)]);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], start_phase_lock};
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        smp_cnt_d  = smp_cnt_q;
        ones_d     = ones_q;
        code_d     = code_q;
        eval_idx_d = eval_idx_q;
        max_d      = max_q;
        best_d     = best_q;
        locked_d   = locked_q;
        err_d      = err_q;
        edge_d     = edge_q;
        samp_d     = samp_q;
        cur_max    = max_q;
        cur_best   = best_q;
        case (state_q)
            IDLE: begin
                code_d   = '0;
                locked_d = 1'b0;
                err_d    = 1'b0;
                edge_d   = '0;
                samp_d   = '{default: '0};
                if (start_s) state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_q == settle_cyc) begin
                    settle_d = '0;
                    state_d  = ACCUM;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ACCUM: begin
                if (enable) begin
                    if (smp_cnt_q == smp_last) begin
                        samp_d[code_q] = norm_sat(ones_inc, avg_log2);
                        smp_cnt_d      = '0;
                        ones_d         = '0;
                        if (code_q != CODE_LAST) begin
                            code_d  = code_q + CODE_W'(1);
                            state_d = SETTLE;
                        end else begin
                            eval_idx_d = '0;
                            state_d    = EVAL;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + CNT_W'(1);
                        ones_d    = ones_inc;
                    end
                end
            end
            EVAL: begin
                if (eval_idx_q == '0) begin
                    cur_max  = diff;
                    cur_best = '0;
                end else if (diff > max_q) begin
                    cur_max  = diff;
                    cur_best = eval_idx_q;
                end
                max_d      = cur_max;
                best_d     = cur_best;
                eval_idx_d = eval_idx_q + CODE_W'(1);
                // Final index: resolve the verdict on the same edge that enters DONE.
                if (eval_idx_q == CODE_LAST) begin
                    state_d = DONE;
                    edge_d  = cur_max;
                    if ((cur_max >= min_edge) && (cur_max != '0)) begin
                        locked_d = 1'b1;
                        err_d    = 1'b0;
                        code_d   = cur_best + code_offset;
                    end else begin
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                        code_d   = cur_best;
                    end
                end
            end
            default: ;
        endcase
        // Dropping the request anywhere outside IDLE discards the run.
        if ((state_q != IDLE) && !start_s) begin
            state_d   = IDLE;
            settle_d  = '0;
            smp_cnt_d = '0;
            ones_d    = '0;
            code_d    = '0;
            locked_d  = 1'b0;
            err_d     = 1'b0;
            edge_d    = '0;
            samp_d    = '{default: '0};
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            smp_cnt_q  <= '0;
            ones_q     <= '0;
            code_q     <= '0;
            eval_idx_q <= '0;
            max_q      <= '0;
            best_q     <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            edge_q     <= '0;
            samp_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            smp_cnt_q  <= smp_cnt_d;
            ones_q     <= ones_d;
            code_q     <= code_d;
            eval_idx_q <= eval_idx_d;
            max_q      <= max_d;
            best_q     <= best_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            edge_q     <= edge_d;
            samp_q     <= samp_d;
        end
    end

    assign phase_sel_code = phase_adjust_ovrd_sel ? phase_sel_code_ovrd : code_q;
    assign phase_locked   = phase_adjust_ovrd_sel ? phase_locked_ovrd : locked_q;
    assign phase_err      = err_q;
    assign edge_strength  = edge_q;
    assign busy           = (state_q == SETTLE) || (state_q == ACCUM) || (state_q == EVAL);

endmodule

// File: tb/tb_phase_cal_fsm.sv
// Directed bench for phase_cal_fsm: a per-code phase-detector pattern model drives
// phase_detect, and each result is compared against hand-computed values.
module tb_phase_cal_fsm;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_phase_lock = 1'b0;
    logic       phase_detect;
    logic       enable;
    logic [2:0] avg_log2 = 3'd3;
    logic [7:0] settle_cyc = 8'd2;
    logic [3:0] min_edge = 4'd4;
    logic [3:0] code_offset = 4'd0;
    logic       phase_adjust_ovrd_sel = 1'b0;
    logic       phase_locked_ovrd = 1'b0;
    logic [3:0] phase_sel_code_ovrd = 4'd0;
    logic [3:0] phase_sel_code;
    logic       phase_locked, phase_err, busy;
    logic [3:0] edge_strength;

    logic [15:0] pat = 16'h0000;
    logic        half_mode = 1'b0;
    logic        en_toggle = 1'b0;
    logic        tog = 1'b0;
    logic [3:0]  held_code = 4'd0;
    logic [3:0]  det_code;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    phase_cal_fsm dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start_phase_lock(start_phase_lock),
        .phase_detect(phase_detect), .enable(enable), .avg_log2(avg_log2),
        .settle_cyc(settle_cyc), .min_edge(min_edge), .code_offset(code_offset),
        .phase_adjust_ovrd_sel(phase_adjust_ovrd_sel), .phase_locked_ovrd(phase_locked_ovrd),
        .phase_sel_code_ovrd(phase_sel_code_ovrd), .phase_sel_code(phase_sel_code),
        .phase_locked(phase_locked), .phase_err(phase_err), .busy(busy),
        .edge_strength(edge_strength)
    );

    always #5 sys_clk = ~sys_clk;

    // Detector model: the mux follows the real code, frozen while the override owns the pins.
    always @(posedge sys_clk) begin
        tog <= ~tog;
        if (!phase_adjust_ovrd_sel) held_code <= phase_sel_code;
    end
    assign det_code     = phase_adjust_ovrd_sel ? held_code : phase_sel_code;
    assign phase_detect = pat[det_code] & (half_mode ? tog : 1'b1);
    assign enable       = en_toggle ? tog : 1'b1;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_done(inout int cnt);
        while (1) begin
            step();
            cnt++;
            if (cnt >= 4 && !busy) break;
            if (cnt >= 2000) begin
                check("wait_done_timeout", cnt, -1);
                break;
            end
        end
    endtask

    task automatic stop_run();
        start_phase_lock = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #2;
        check("rst_code", phase_sel_code, 0);
        check("rst_locked", phase_locked, 0);
        check("rst_err", phase_err, 0);
        check("rst_busy", busy, 0);
        check("rst_edge", edge_strength, 0);
        rst_n = 1'b1;
        step();

        // Main lock: edge at code 6, exact latency to DONE
        pat = 16'h3FC0;
        start_phase_lock = 1'b1; n = 0;
        wait_done(n);
        check("s1_latency", n, 195);
        check("s1_locked", phase_locked, 1);
        check("s1_err", phase_err, 0);
        check("s1_code", phase_sel_code, 6);
        check("s1_edge", edge_strength, 15);
        repeat (5) step();
        check("s1_hold_code", phase_sel_code, 6);
        check("s1_hold_busy", busy, 0);
        stop_run();
        check("s1_abort_code", phase_sel_code, 0);
        check("s1_abort_locked", phase_locked, 0);
        check("s1_abort_edge", edge_strength, 0);

        // Offset wraps modulo NPHASE
        code_offset = 4'd12;
        start_phase_lock = 1'b1; n = 0;
        wait_done(n);
        check("off_code", phase_sel_code, 2);
        check("off_locked", phase_locked, 1);
        stop_run();
        code_offset = 4'd0;

        // Edge crossing the circular wrap (13->14)
        pat = 16'hC00F;
        start_phase_lock = 1'b1; n = 0;
        wait_done(n);
        check("wrap_code", phase_sel_code, 14);
        check("wrap_locked", phase_locked, 1);
        stop_run();

        // Two equal edges: lower index wins
        pat = 16'h1C1C;
        start_phase_lock = 1'b1; n = 0;
        wait_done(n);
        check("tie_code", phase_sel_code, 2);
        check("tie_edge", edge_strength, 15);
        stop_run();

        // Flat profile -> error
        pat = 16'h0000;
        start_phase_lock = 1'b1; n = 0;
        wait_done(n);
        check("flat_err", phase_err, 1);
        check("flat_locked", phase_locked, 0);
        check("flat_busy", busy, 0);
        check("flat_edge", edge_strength, 0);
        check("flat_code", phase_sel_code, 0);
        stop_run();

        // Half-strength edge (8) below min_edge 15 -> error, code = best
        pat = 16'h3FC0; half_mode = 1'b1; avg_log2 = 3'd1; min_edge = 4'd15;
        start_phase_lock = 1'b1; n = 0;
        wait_done(n);
        check("half_latency", n, 99);
        check("half_err", phase_err, 1);
        check("half_locked", phase_locked, 0);
        check("half_edge", edge_strength, 8);
        check("half_code", phase_sel_code, 6);
        stop_run();
        half_mode = 1'b0; avg_log2 = 3'd3; min_edge = 4'd4;

        // Enable at 50%: same result, ACCUM roughly doubled
        en_toggle = 1'b1;
        start_phase_lock = 1'b1; n = 0;
        wait_done(n);
        check("entog_time", int'(n >= 307 && n <= 323), 1);
        check("entog_code", phase_sel_code, 6);
        check("entog_locked", phase_locked, 1);
        check("entog_edge", edge_strength, 15);
        stop_run();
        en_toggle = 1'b0;

        // Abort in ACCUM of code 1
        start_phase_lock = 1'b1;
        repeat (19) step();
        check("abort_pre_code", phase_sel_code, 1);
        check("abort_pre_busy", busy, 1);
        start_phase_lock = 1'b0;
        repeat (2) step();
        check("abort_still_busy", busy, 1);
        step();
        check("abort_busy", busy, 0);
        check("abort_code", phase_sel_code, 0);
        check("abort_locked", phase_locked, 0);
        step();

        // Restart after abort, with override pulsed mid-run
        start_phase_lock = 1'b1; n = 0;
        repeat (26) step();
        n = 26;
        phase_sel_code_ovrd = 4'd9; phase_locked_ovrd = 1'b1; phase_adjust_ovrd_sel = 1'b1;
        #1;
        check("ovrd_code", phase_sel_code, 9);
        check("ovrd_locked", phase_locked, 1);
        check("ovrd_busy", busy, 1);
        repeat (3) step();
        n = n + 3;
        phase_adjust_ovrd_sel = 1'b0;
        #1;
        check("ovrd_release_code", phase_sel_code, 2);
        check("ovrd_release_locked", phase_locked, 0);
        wait_done(n);
        check("restart_latency", n, 195);
        check("restart_code", phase_sel_code, 6);
        check("restart_locked", phase_locked, 1);
        stop_run();

        // Async reset during EVAL
        start_phase_lock = 1'b1;
        repeat (184) step();
        check("eval_busy", busy, 1);
        check("eval_code", phase_sel_code, 15);
        #2 rst_n = 1'b0;
        #1;
        check("arst_code", phase_sel_code, 0);
        check("arst_busy", busy, 0);
        check("arst_locked", phase_locked, 0);
        check("arst_err", phase_err, 0);
        start_phase_lock = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("arst_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_cal_fsm.md
Name: phase_cal_fsm

Overview:
Parametrised successor to the AIB phase-adjust calibration FSM. It sweeps a configurable number of phase-select codes and waits a programmable settle time after each code change. At each code it averages 2^avg_log2 phase-detector samples, then scans the stored profile circularly for the strongest 0->1 rising edge. It outputs the locked code with a programmable offset, or flags an error when no edge reaches a programmable minimum strength. It sits between the sys_clk-domain phase-detect sampler and the DLL/PI phase-select mux in the AIB adapter.

Parameters:
NPHASE, 16, number of phase codes; power of 2, range 2..64
CODE_W, $clog2(NPHASE), phase code width
SAMP_W, 4, width of each stored normalised sample
AVG_MAX, 7, maximum legal avg_log2

Ports:
sys_clk  in  1  system clock; sole clock
rst_n  in  1  asynchronous active-low reset
start_phase_lock  in  1  level request, asynchronous; synchronised internally by aib_bit_sync to sys_clk
phase_detect  in  1  phase-detector sample, already synchronous to sys_clk
enable  in  1  sample qualifier; a sample counts only when enable=1
avg_log2  in  3  log2 of samples per code, 0..AVG_MAX; quasi-static
settle_cyc  in  8  settle cycles after each code change; quasi-static
min_edge  in  SAMP_W  minimum winning edge strength for lock
code_offset  in  CODE_W  added modulo NPHASE to the winning code
phase_adjust_ovrd_sel  in  1  1 = outputs driven from the override inputs
phase_locked_ovrd  in  1  override value for phase_locked
phase_sel_code_ovrd  in  CODE_W  override value for phase_sel_code
phase_sel_code  out  CODE_W  phase code, muxed with override
phase_locked  out  1  calibration succeeded, muxed with override
phase_err  out  1  calibration done, no valid edge; not overridden
busy  out  1  1 in SETTLE, ACCUM or EVAL
edge_strength  out  SAMP_W  max edge difference found; held in DONE

Behaviour:
- Reset values: all registers 0; state IDLE; outputs 0. With ovrd_sel=1, override values pass through combinationally.
- Synchronised start (start_s) lags start_phase_lock by 2 sys_clk cycles.
- IDLE: code=0, locked=0, err=0, profile cleared. If start_s=1, go to SETTLE with code=0.
- SETTLE: counter runs from 0. Exit to ACCUM on the cycle counter==settle_cyc, so SETTLE occupies settle_cyc+1 cycles. Counter clears on exit.
- ACCUM: when enable=1, smp_cnt increments, and ones increments if phase_detect=1. Counter widths are AVG_MAX+1. When enable=1 and smp_cnt==2^avg_log2-1, the final sample is included and the code's result is written, on that same clock edge, to samp[code] = min((ones<<SAMP_W)>>avg_log2, 2^SAMP_W-1). The counters then clear.
  - If code<NPHASE-1: code increments and the FSM returns to SETTLE.
  - Otherwise: go to EVAL with eval_idx=0.
  - When enable=0, the counters hold.
- EVAL: one index per cycle, i=eval_idx.
  - diff = samp[i]-samp[(i-1) mod NPHASE] if samp[i] >= that neighbour, else 0. Index 0 wraps to NPHASE-1.
  - i=0 initialises max=diff, best=0.
  - Later indices update only if diff > max (strict), so ties go to the lowest index.
  - After i=NPHASE-1, go to DONE. EVAL lasts exactly NPHASE cycles.
- DONE, entered with max and best:
  - If max >= min_edge and max != 0: locked=1, err=0, code=(best+code_offset) mod NPHASE.
  - Otherwise: locked=0, err=1, code=best.
  - edge_strength=max. All outputs hold while start_s=1.
- start_s=0 in any non-IDLE state aborts to IDLE on the next edge. Abort clears code, locked, err, edge_strength and the profile; partial data is discarded.
- A flat profile, all-equal or monotonic with no positive step, gives max=0, so err=1.
- Async reset mid-operation returns everything to reset values immediately.
- Changing avg_log2, settle_cyc or min_edge while busy=1 is illegal; results are undefined, but the FSM must not hang.
- Latency with enable held 1: 2 (sync) + 1 (IDLE) + NPHASE*(settle_cyc+1+2^avg_log2) + NPHASE cycles to DONE entry.

Test Plan:
- NPHASE=16, avg_log2=3, settle_cyc=2, enable=1. phase_detect=1 only for codes 6..13, min_edge=4, code_offset=0 -> DONE after 2+1+16*11+16=195 cycles; locked=1, code=6, edge_strength=15.
- Same profile, code_offset=12 -> code=(6+12) mod 16=2, locked=1.
- phase_detect=1 for codes 0..3 and 14..15, so the edge wraps at 13->14 -> code=14. A second equal edge at a lower index wins the tie.
- phase_detect constant 0 -> max=0, err=1, locked=0, busy=0. Raising min_edge=15 with a half-strength edge (avg_log2=1, value 8) -> err=1.
- enable toggled 50% in ACCUM -> identical result to the first scenario, with ACCUM time doubled. start deasserted mid-ACCUM -> IDLE 3 cycles later, outputs 0. Restart -> normal lock.
- ovrd_sel=1, ovrd code=9, locked_ovrd=1 during a run -> outputs 9/1 immediately, with internal state unaffected. rst_n pulsed in EVAL -> all outputs 0 asynchronously.
